// File: rtl/noc_rx_port_if.sv
// Router input port bus: upstream flit channel, switch request/grant and buffer read port.
interface noc_rx_port_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CHNL_W = 3
);
    logic              ch_req;
    logic [DATA_W-1:0] ch_flit;
    logic              ch_ack;
    logic              sw_req;
    logic [CHNL_W-1:0] sw_chnl;
    logic              sw_gnt;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    // Port side: receives flits, requests the switch, serves buffer reads
    modport slave (
        input  ch_req, ch_flit, sw_gnt, buf_addr,
        output ch_ack, sw_req, sw_chnl, buf_data
    );

    // Environment side: upstream link plus switch/arbiter
    modport master (
        output ch_req, ch_flit, sw_gnt, buf_addr,
        input  ch_ack, sw_req, sw_chnl, buf_data
    );
endinterface

// File: rtl/noc_rx_port.sv
// Router input port: buffers one packet of up to DEPTH flits, decodes the
// header's channel/length, requests the switch and exposes the buffer for reads.
// Optional feature macro: RX_STATS_EN adds a 16-bit released-packet counter (pkt_cnt).
module noc_rx_port #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CHNL_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    noc_rx_port_if.slave    bus
`ifdef RX_STATS_EN
    ,
    output logic [15:0]     pkt_cnt
`endif
);
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned LEN_LSB = CHNL_W;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        REQ  = 2'd1,
        GNT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]   pkt_len;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  hdr_len_m1;
    logic               ack_c;
    logic               last_c;
    logic               rel_c;

    assign hdr_len_m1 = bus.ch_flit[LEN_LSB +: ADDR_W];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RECV;
        else       state <= state_nxt;
    end

    // Next state, flit acceptance and packet release
    always_comb begin
        state_nxt = state;
        ack_c     = 1'b0;
        last_c    = 1'b0;
        rel_c     = 1'b0;
        case (state)
            RECV: begin
                ack_c = bus.ch_req & ~reset;
                // The header carries the length; later flits compare against the latched length
                if (wr_ptr == '0) last_c = (hdr_len_m1 == '0);
                else              last_c = ({1'b0, wr_ptr} == (pkt_len - LEN_W'(1)));
                if (ack_c && last_c) state_nxt = REQ;
            end
            REQ: begin
                if (bus.sw_gnt) state_nxt = GNT;
            end
            GNT: begin
                if (!bus.sw_gnt) begin
                    rel_c     = 1'b1;
                    state_nxt = RECV;
                end
            end
            default: state_nxt = RECV;
        endcase
    end

    assign bus.ch_ack   = ack_c;
    assign bus.buf_data = mem[bus.buf_addr];

    // Buffer write, header decode and switch request
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            pkt_len     <= '0;
            bus.sw_req  <= 1'b0;
            bus.sw_chnl <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            bus.sw_req <= (state_nxt != RECV);
            if (ack_c) begin
                mem[wr_ptr] <= bus.ch_flit;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
                if (wr_ptr == '0) begin
                    bus.sw_chnl <= bus.ch_flit[CHNL_W-1:0];
                    pkt_len     <= LEN_W'(hdr_len_m1) + LEN_W'(1);
                end
            end
            if (rel_c) wr_ptr <= '0;
        end
    end

`ifdef RX_STATS_EN
    // Released-packet counter, wraps at 16 bits
    always_ff @(posedge clk) begin
        if (reset)      pkt_cnt <= '0;
        else if (rel_c) pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_noc_rx_port.sv
// Directed bench for noc_rx_port: reset, a vector table for the 3-flit/grant/
// single-flit flow, and hand sequences for max-length packet and mid-packet reset.
module tb_noc_rx_port;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    noc_rx_port_if bus ();

`ifdef RX_STATS_EN
    logic [15:0] pkt_cnt;
    noc_rx_port dut (.clk(clk), .reset(reset), .bus(bus), .pkt_cnt(pkt_cnt));
`else
    noc_rx_port dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [7:0] flit;
        logic       gnt;
        logic [2:0] addr;
        logic       e_ack;
        logic       e_sreq;
        logic [2:0] e_chnl;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Drive one flit and require it to be accepted this cycle
    task automatic send_flit(input string nm, input logic [7:0] f);
        bus.ch_req  = 1'b1;
        bus.ch_flit = f;
        @(negedge clk);
        chk(nm, 16'(bus.ch_ack), 16'd1);
        @(posedge clk);
        #1;
        bus.ch_req = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset        = 1'b1;
        bus.ch_req   = 1'b1;
        bus.ch_flit  = 8'hEE;
        bus.sw_gnt   = 1'b0;
        bus.buf_addr = 3'd0;

        // ---- reset held with ch_req high; buffer reads zero everywhere
        @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
            bus.buf_addr = 3'(a);
            @(negedge clk);
            chk($sformatf("rst ack a%0d", a), 16'(bus.ch_ack), 16'd0);
            chk($sformatf("rst data a%0d", a), 16'(bus.buf_data), 16'd0);
            if (a == 0) begin
                chk("rst sw_req", 16'(bus.sw_req), 16'd0);
                chk("rst sw_chnl", 16'(bus.sw_chnl), 16'd0);
            end
            @(posedge clk);
            #1;
        end
`ifdef RX_STATS_EN
        chk("rst pkt_cnt", pkt_cnt, 16'd0);
`endif
        reset      = 1'b0;
        bus.ch_req = 1'b0;

        // ---- table: 3-flit packet, grant/release, gnt-in-RECV, single flit
        //              req  flit   gnt  addr  ack  sreq chnl data
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{1'b1, 8'h15, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[2]  = '{1'b1, 8'hA1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 8'h15};
        tbl[3]  = '{1'b0, 8'hA2, 1'b0, 3'd1, 1'b0, 1'b0, 3'd5, 8'hA1};
        tbl[4]  = '{1'b1, 8'hA2, 1'b0, 3'd2, 1'b1, 1'b0, 3'd5, 8'h00};
        tbl[5]  = '{1'b1, 8'h77, 1'b0, 3'd2, 1'b0, 1'b1, 3'd5, 8'hA2};
        tbl[6]  = '{1'b1, 8'h77, 1'b1, 3'd0, 1'b0, 1'b1, 3'd5, 8'h15};
        tbl[7]  = '{1'b1, 8'h77, 1'b1, 3'd1, 1'b0, 1'b1, 3'd5, 8'hA1};
        tbl[8]  = '{1'b1, 8'h77, 1'b1, 3'd2, 1'b0, 1'b1, 3'd5, 8'hA2};
        tbl[9]  = '{1'b1, 8'h77, 1'b0, 3'd3, 1'b0, 1'b1, 3'd5, 8'h00};
        tbl[10] = '{1'b1, 8'h02, 1'b1, 3'd0, 1'b1, 1'b0, 3'd5, 8'h15};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 8'h02};
        tbl[12] = '{1'b1, 8'h55, 1'b1, 3'd1, 1'b0, 1'b1, 3'd2, 8'hA1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 8'h02};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2, 8'hA2};

        for (int i = 0; i < 15; i++) begin
            bus.ch_req   = tbl[i].req;
            bus.ch_flit  = tbl[i].flit;
            bus.sw_gnt   = tbl[i].gnt;
            bus.buf_addr = tbl[i].addr;
            @(negedge clk);
            chk($sformatf("vec%0d ch_ack", i), 16'(bus.ch_ack), 16'(tbl[i].e_ack));
            chk($sformatf("vec%0d sw_req", i), 16'(bus.sw_req), 16'(tbl[i].e_sreq));
            chk($sformatf("vec%0d sw_chnl", i), 16'(bus.sw_chnl), 16'(tbl[i].e_chnl));
            chk($sformatf("vec%0d buf_data", i), 16'(bus.buf_data), 16'(tbl[i].e_data));
            @(posedge clk);
            #1;
        end
        bus.ch_req = 1'b0;
        bus.sw_gnt = 1'b0;
`ifdef RX_STATS_EN
        chk("tbl pkt_cnt", pkt_cnt, 16'd2);
`endif

        // ---- max packet: header 38 (L=8, chnl 0) plus 7 payload flits
        send_flit("max hdr ack", 8'h38);
        for (int k = 1; k < 8; k++) send_flit($sformatf("max flit%0d ack", k), 8'(8'hC0 + k));
        bus.ch_req  = 1'b1;
        bus.ch_flit = 8'hFF;
        @(negedge clk);
        chk("max 9th ack", 16'(bus.ch_ack), 16'd0);
        chk("max sw_req", 16'(bus.sw_req), 16'd1);
        chk("max sw_chnl", 16'(bus.sw_chnl), 16'd0);
        @(posedge clk);
        #1;
        bus.ch_req = 1'b0;
        bus.sw_gnt = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.buf_addr = 3'(a);
            @(negedge clk);
            chk($sformatf("max data a%0d", a), 16'(bus.buf_data),
                (a == 0) ? 16'h0038 : 16'(8'hC0 + a));
            @(posedge clk);
            #1;
        end
        bus.sw_gnt = 1'b0;
        @(negedge clk);
        chk("max sw_req before release", 16'(bus.sw_req), 16'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("max sw_req after release", 16'(bus.sw_req), 16'd0);
`ifdef RX_STATS_EN
        chk("max pkt_cnt", pkt_cnt, 16'd3);
`endif
        @(posedge clk);
        #1;

        // ---- reset mid-packet: 2 of 4 flits of header 1B, then reset
        send_flit("mid hdr ack", 8'h1B);
        send_flit("mid flit1 ack", 8'hD1);
        reset       = 1'b1;
        bus.ch_req  = 1'b1;
        bus.ch_flit = 8'hD2;
        @(negedge clk);
        chk("mid ack in reset", 16'(bus.ch_ack), 16'd0);
        chk("mid chnl before reset", 16'(bus.sw_chnl), 16'd3);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.ch_req = 1'b0;
        bus.buf_addr = 3'd0;
        @(negedge clk);
        chk("mid chnl after reset", 16'(bus.sw_chnl), 16'd0);
        chk("mid data after reset", 16'(bus.buf_data), 16'd0);
        @(posedge clk);
        #1;
        send_flit("mid new hdr ack", 8'h09);
        send_flit("mid new flit ack", 8'hE2);
        @(negedge clk);
        chk("mid sw_req", 16'(bus.sw_req), 16'd1);
        chk("mid sw_chnl", 16'(bus.sw_chnl), 16'd1);
        chk("mid data a0", 16'(bus.buf_data), 16'h0009);
        bus.buf_addr = 3'd1;
        #1;
        chk("mid data a1", 16'(bus.buf_data), 16'h00E2);
        @(posedge clk);
        #1;
        bus.sw_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.sw_gnt = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid sw_req released", 16'(bus.sw_req), 16'd0);
`ifdef RX_STATS_EN
        chk("mid pkt_cnt", pkt_cnt, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
